// File: rtl/afifo_pkg.sv
// Shared types and constants for the async FIFO read-side consumer.
package afifo_pkg;

  localparam int AFIFO_DW   = 8;
  localparam int AFIFO_CW   = 16;
  localparam int SKID_DEPTH = 2;

  typedef logic [AFIFO_DW-1:0] data_t;
  typedef logic [AFIFO_CW-1:0] cnt_t;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    DRAIN   = 2'd1,
    FLUSHED = 2'd2
  } drain_state_e;

endpackage

// File: rtl/afifo_rd_skid.sv
// Two-entry FIFO-ordered skid buffer; clear empties it and wins over any write.
module afifo_rd_skid
  import afifo_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          wr,
  input  logic [DW-1:0] wr_data,
  input  logic          leave,
  output logic [1:0]    occ,
  output logic [DW-1:0] head
);

  logic [DW-1:0] mem_r [SKID_DEPTH];
  logic          wr_ptr_r;
  logic          rd_ptr_r;
  logic [1:0]    occ_r;
  logic          leave_s;

  assign leave_s = leave && (occ_r != 2'd0);
  assign occ     = occ_r;
  assign head    = mem_r[rd_ptr_r];

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SKID_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else if (clear) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      occ_r    <= 2'd0;
    end else begin
      if (wr) begin
        mem_r[wr_ptr_r] <= wr_data;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (leave_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      occ_r <= occ_r + {1'b0, wr} - {1'b0, leave_s};
    end
  end

endmodule

// File: rtl/afifo_rd_drain.sv
// Read-side consumer: pops the FIFO, checks an incrementing sequence, buffers
// words for a valid/ready sink, and can drain the FIFO discarding its contents.
module afifo_rd_drain
  import afifo_pkg::*;
#(
  parameter int DW = 8,
  parameter int CW = 16
) (
  input  logic          rd_clk,
  input  logic          rd_rst,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rd_data,
  output logic          fifo_pop,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready,
  input  logic          drain_req,
  output logic          drain_done,
  output logic [CW-1:0] word_cnt,
  output logic [CW-1:0] err_cnt
);

  localparam logic [1:0] ST_RUN     = RUN;
  localparam logic [1:0] ST_DRAIN   = DRAIN;
  localparam logic [1:0] ST_FLUSHED = FLUSHED;

  logic [1:0]    state_r;
  logic [1:0]    state_nxt_s;
  logic          inflight_r;
  logic [DW-1:0] exp_r;
  logic [CW-1:0] word_cnt_r;
  logic [CW-1:0] err_cnt_r;
  logic          drain_done_r;
  logic [1:0]    occ_s;
  logic [DW-1:0] head_s;
  logic          leave_s;
  logic [2:0]    load_s;
  logic          pop_s;
  logic          skid_wr_s;
  logic          skid_clear_s;

  assign m_valid      = (occ_s != 2'd0) && (state_r == ST_RUN);
  assign m_data       = head_s;
  assign leave_s      = m_valid && m_ready;
  assign load_s       = {1'b0, occ_s} + {2'b00, inflight_r} - {2'b00, leave_s};
  assign skid_wr_s    = inflight_r && (state_r == ST_RUN);
  assign skid_clear_s = (state_r == ST_RUN) && drain_req;
  assign fifo_pop     = pop_s;
  assign drain_done   = drain_done_r;
  assign word_cnt     = word_cnt_r;
  assign err_cnt      = err_cnt_r;

  // Pop request; held low during reset so no word is lost while the core restarts.
  always_comb begin
    pop_s = 1'b0;
    if (rd_rst) begin
      pop_s = 1'b0;
    end else begin
      case (state_r)
        ST_RUN:   pop_s = !fifo_empty && (load_s < 3'd2);
        ST_DRAIN: pop_s = !fifo_empty;
        default:  pop_s = 1'b0;
      endcase
    end
  end

  // Next-state logic for RUN / DRAIN / FLUSHED.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (drain_req) state_nxt_s = ST_DRAIN;
        else           state_nxt_s = ST_RUN;
      end
      ST_DRAIN: begin
        if (fifo_empty && !inflight_r) state_nxt_s = ST_FLUSHED;
        else                           state_nxt_s = ST_DRAIN;
      end
      ST_FLUSHED: state_nxt_s = ST_RUN;
      default:    state_nxt_s = ST_RUN;
    endcase
  end

  // State register and one-cycle drain completion pulse.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_r      <= ST_RUN;
      drain_done_r <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      drain_done_r <= (state_nxt_s == ST_FLUSHED);
    end
  end

  // Capture, sequence check (resync on mismatch) and counters.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      inflight_r <= 1'b0;
      exp_r      <= '0;
      word_cnt_r <= '0;
      err_cnt_r  <= '0;
    end else begin
      inflight_r <= pop_s;
      if (inflight_r) begin
        word_cnt_r <= word_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        exp_r      <= fifo_rd_data + {{(DW-1){1'b0}}, 1'b1};
        if ((fifo_rd_data != exp_r) && (err_cnt_r != {CW{1'b1}})) begin
          err_cnt_r <= err_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  afifo_rd_skid #(.DW(DW)) u_skid (
    .clk     (rd_clk),
    .rst     (rd_rst),
    .clear   (skid_clear_s),
    .wr      (skid_wr_s),
    .wr_data (fifo_rd_data),
    .leave   (leave_s),
    .occ     (occ_s),
    .head    (head_s)
  );

endmodule

// File: tb/tb_afifo_rd_drain.sv
// Randomized self-checking bench for afifo_rd_drain against a queue-based model.
module tb_afifo_rd_drain;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          rd_clk = 1'b0;
  logic          rd_rst;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd_data;
  logic          fifo_pop;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic          drain_req;
  logic          drain_done;
  logic [CW-1:0] word_cnt;
  logic [CW-1:0] err_cnt;

  always #5 rd_clk = ~rd_clk;

  afifo_rd_drain #(.DW(DW), .CW(CW)) dut (
    .rd_clk       (rd_clk),
    .rd_rst       (rd_rst),
    .fifo_empty   (fifo_empty),
    .fifo_rd_data (fifo_rd_data),
    .fifo_pop     (fifo_pop),
    .m_valid      (m_valid),
    .m_data       (m_data),
    .m_ready      (m_ready),
    .drain_req    (drain_req),
    .drain_done   (drain_done),
    .word_cnt     (word_cnt),
    .err_cnt      (err_cnt)
  );

  typedef enum {M_RUN, M_DRAIN, M_FLUSHED} mode_e;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] sb_q [$];
  mode_e         mode;
  logic          pend_valid;
  logic [DW-1:0] pend_word;
  logic [DW-1:0] exp_m;
  int            err_m;
  int            wcnt_m;
  int            done_seen;
  int            deliv;
  int            cyc;
  int            first_pop;
  int            first_valid;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, obs, expv, $time);
    end
  endtask

  task automatic model_reset();
    mode       = M_RUN;
    sb_q.delete();
    pend_valid = 1'b0;
    exp_m      = '0;
    err_m      = 0;
    wcnt_m     = 0;
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic step(input logic rst, input logic ready, input logic drain);
    logic exp_valid;
    logic leave_e;
    logic pop_e;
    int   load;
    check_val("word_cnt", word_cnt, wcnt_m);
    check_val("err_cnt", err_cnt, err_m);
    if (pend_valid) fifo_rd_data = pend_word;
    else            fifo_rd_data = DW'($urandom);
    rd_rst     = rst;
    m_ready    = ready;
    drain_req  = drain;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    exp_valid = (mode == M_RUN) && (sb_q.size() > 0);
    leave_e   = exp_valid && ready;
    load      = sb_q.size() + (pend_valid ? 1 : 0) - (leave_e ? 1 : 0);
    if (rst)                  pop_e = 1'b0;
    else if (mode == M_RUN)   pop_e = !fifo_empty && (load < 2);
    else if (mode == M_DRAIN) pop_e = !fifo_empty;
    else                      pop_e = 1'b0;
    check_val("m_valid", m_valid, exp_valid);
    if (exp_valid) check_val("m_data", m_data, sb_q[0]);
    check_val("fifo_pop", fifo_pop, pop_e);
    check_val("drain_done", drain_done, mode == M_FLUSHED);
    if (drain_done === 1'b1) done_seen++;
    if (fifo_pop === 1'b1 && first_pop < 0) first_pop = cyc;
    if (m_valid === 1'b1 && first_valid < 0) first_valid = cyc;
    if (rst) begin
      model_reset();
    end else begin
      if (leave_e) begin
        void'(sb_q.pop_front());
        deliv++;
      end
      if (pend_valid) begin
        wcnt_m++;
        if (pend_word != exp_m && err_m < (2**CW - 1)) err_m++;
        exp_m = pend_word + 8'd1;
        if (mode == M_RUN) sb_q.push_back(pend_word);
      end
      case (mode)
        M_RUN:     if (drain) begin mode = M_DRAIN; sb_q.delete(); end
        M_DRAIN:   if (fifo_q.size() == 0 && !pend_valid) mode = M_FLUSHED;
        default:   mode = M_RUN;
      endcase
      if (fifo_pop === 1'b1 && fifo_q.size() > 0) begin
        pend_word  = fifo_q.pop_front();
        pend_valid = 1'b1;
      end else begin
        pend_valid = 1'b0;
      end
    end
    cyc++;
    @(negedge rd_clk);
  endtask

  task automatic fill(input int first, input int n);
    fifo_q.delete();
    for (int i = 0; i < n; i++) fifo_q.push_back(DW'(first + i));
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
    deliv = 0; done_seen = 0; first_pop = -1; first_valid = -1; cyc = 0;
  endtask

  initial begin
    rd_rst = 1'b1; m_ready = 1'b0; drain_req = 1'b0;
    fifo_empty = 1'b1; fifo_rd_data = '0;
    deliv = 0; done_seen = 0; cyc = 0; first_pop = -1; first_valid = -1;
    model_reset();
    fill(0, 5);
    @(negedge rd_clk);
    // Reset with the FIFO non-empty: no pops, outputs and counters idle.
    do_reset(3);

    // Streaming 0..14 with a ready sink.
    fill(0, 15);
    for (int i = 0; i < 25; i++) step(1'b0, 1'b1, 1'b0);
    check_val("stream_latency", first_valid - first_pop, 2);
    check_val("stream_deliv", deliv, 15);
    check_val("stream_wcnt", word_cnt, 15);
    check_val("stream_err", err_cnt, 0);

    // Backpressure: ready toggles every cycle.
    do_reset(2);
    fill(0, 20);
    for (int i = 0; i < 60; i++) step(1'b0, logic'(i % 2), 1'b0);
    check_val("bp_deliv", deliv, 20);
    check_val("bp_err", err_cnt, 0);

    // Sequence errors with resync.
    do_reset(2);
    fifo_q = '{8'd0, 8'd1, 8'd2, 8'd7, 8'd8, 8'd3};
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b0);
    check_val("seq_err", err_cnt, 2);
    check_val("seq_wcnt", word_cnt, 6);

    // Drain with two words buffered and the sink stalled.
    do_reset(2);
    fill(0, 10);
    for (int i = 0; i < 10 && sb_q.size() < 2; i++) step(1'b0, 1'b0, 1'b0);
    check_val("drain_buffered", sb_q.size(), 2);
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 40 && !(done_seen == 1 && mode == M_RUN); i++) step(1'b0, 1'b0, 1'b0);
    check_val("drain_done_cnt", done_seen, 1);
    check_val("drain_back_run", mode == M_RUN, 1'b1);
    check_val("drain_wcnt", word_cnt, 10);
    check_val("drain_deliv", deliv, 0);

    // Reset while draining: no completion pulse, counters cleared.
    do_reset(2);
    fill(0, 10);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check_val("rstdrain_mode", mode == M_DRAIN, 1'b1);
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    check_val("rstdrain_done", done_seen, 0);
    check_val("rstdrain_wcnt", word_cnt, 0);
    check_val("rstdrain_err", err_cnt, 0);

    // Random traffic, occasional corrupted words and drains.
    do_reset(2);
    fifo_q.delete();
    begin
      logic [DW-1:0] seq = '0;
      for (int i = 0; i < 400; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          if ($urandom_range(0, 7) == 0) fifo_q.push_back(DW'($urandom));
          else                           fifo_q.push_back(seq);
          seq = seq + 8'd1;
        end
        step(1'b0, logic'($urandom_range(0, 1)), logic'($urandom_range(0, 49) == 0));
      end
    end
    for (int i = 0; i < 60; i++) step(1'b0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
